// File: rtl/div_quot_bcd_if.sv
// div_quot_bcd_if: input/output handshake bundle for the quotient-to-BCD stage
//   in_valid/in_ready/quot/div_zero : quotient side, accepted when both valid and ready
//   out_valid/out_ready/bcd/err     : result side, held until out_ready
interface div_quot_bcd_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      quot;
   logic                  div_zero;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd;
   logic                  err;
   modport master (output in_valid, quot, div_zero, out_ready, input in_ready, out_valid, bcd, err);
   modport slave  (input in_valid, quot, div_zero, out_ready, output in_ready, out_valid, bcd, err);
endinterface

// File: rtl/div_quot_bcd.sv
// div_quot_bcd: registers a WIDTH-bit quotient and converts it to packed BCD by double-dabble
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of div_quot_bcd_if (quotient in, BCD result / divide-by-zero flag out)
module div_quot_bcd #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input logic             clk,
   input logic             rst,
   div_quot_bcd_if.slave   bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int AW = 4 * DIGITS;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_sr;
   logic [AW-1:0]    r_acc;
   logic [CW-1:0]    r_cnt;
   logic             r_dz;
   logic [AW-1:0]    r_bcd;
   logic             r_err;
   logic             r_out_valid;
   logic [AW-1:0]    w_adj;
   logic [AW-1:0]    w_next;
   // add-3 correction on every digit before the shift, so no digit overflows past 9
   for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      assign w_adj[4*d+:4] = (r_acc[4*d+:4] >= 4'd5) ? r_acc[4*d+:4] + 4'd3 : r_acc[4*d+:4];
   end
   assign w_next        = {w_adj[AW-2:0], r_sr[WIDTH-1]};
   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.bcd       = r_bcd;
   assign bus.err       = r_err;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_bcd       <= '0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.in_valid) begin
               r_sr    <= bus.quot;
               r_acc   <= '0;
               r_dz    <= bus.div_zero;
               r_cnt   <= '0;
               r_state <= bus.div_zero ? DONE : SHIFT;
            end
            SHIFT: begin
               r_acc <= w_next;
               r_sr  <= r_sr << 1;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_bcd       <= w_next;
                  r_err       <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               // arriving without out_valid only happens on the divide-by-zero path
               if (!r_out_valid) begin
                  r_bcd       <= '1;
                  r_err       <= r_dz;
                  r_out_valid <= 1'b1;
               end else if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_quot_bcd.sv
// tb_div_quot_bcd: vector table, corner sequences and random/exhaustive sweeps against a decimal model
module tb_div_quot_bcd;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   always #5 clk = ~clk;
   div_quot_bcd_if #(.WIDTH(8), .DIGITS(3)) bus ();
   div_quot_bcd #(.WIDTH(8), .DIGITS(3)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      logic [7:0]  q;
      logic        dz;
      logic [11:0] b;
      logic        e;
      int          lat;
   } vec_t;
   vec_t tbl[12];
   function automatic logic [11:0] bcd_ref(input int q);
      return {4'(q / 100), 4'((q / 10) % 10), 4'(q % 10)};
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic convert(input logic [7:0] q, input logic dz, input logic [11:0] b, input logic e, input int lat);
      int n = 0;
      int busy_bad = 0;
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      check("in_ready_wait", 32'(bus.in_ready), 32'd1);
      bus.in_valid  = 1'b1;
      bus.quot      = q;
      bus.div_zero  = dz;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.quot     = 8'h00;
      bus.div_zero = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 50) begin
         if (bus.in_ready) busy_bad++;
         tick();
         n++;
      end
      check("latency", 32'(n), 32'(lat));
      check("in_ready_busy", 32'(busy_bad + int'(bus.in_ready)), 32'd0);
      check("bcd", 32'(bus.bcd), 32'(b));
      check("err", 32'(bus.err), 32'(e));
      tick();
      check("post_out_valid", 32'(bus.out_valid), 32'd0);
      check("post_in_ready", 32'(bus.in_ready), 32'd1);
   endtask
   initial begin
      int n;
      logic [7:0] rq;
      logic rdz;
      tbl[0]  = '{8'd10,  1'b0, 12'h010, 1'b0, 8};
      tbl[1]  = '{8'd5,   1'b0, 12'h005, 1'b0, 8};
      tbl[2]  = '{8'd9,   1'b0, 12'h009, 1'b0, 8};
      tbl[3]  = '{8'd7,   1'b0, 12'h007, 1'b0, 8};
      tbl[4]  = '{8'd5,   1'b0, 12'h005, 1'b0, 8};
      tbl[5]  = '{8'd51,  1'b0, 12'h051, 1'b0, 8};
      tbl[6]  = '{8'd0,   1'b0, 12'h000, 1'b0, 8};
      tbl[7]  = '{8'd255, 1'b0, 12'h255, 1'b0, 8};
      tbl[8]  = '{8'd99,  1'b0, 12'h099, 1'b0, 8};
      tbl[9]  = '{8'd100, 1'b0, 12'h100, 1'b0, 8};
      tbl[10] = '{8'hA7,  1'b1, 12'hFFF, 1'b1, 1};
      tbl[11] = '{8'd42,  1'b0, 12'h042, 1'b0, 8};
      bus.in_valid  = 1'b0;
      bus.quot      = 8'h00;
      bus.div_zero  = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_bcd", 32'(bus.bcd), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      for (int i = 0; i < 12; i++) convert(tbl[i].q, tbl[i].dz, tbl[i].b, tbl[i].e, tbl[i].lat);
      // backpressure: result held, competing input ignored until handshake
      bus.in_valid  = 1'b1;
      bus.quot      = 8'd85;
      bus.div_zero  = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 50) begin
         tick();
         n++;
      end
      check("bp_latency", 32'(n), 32'd8);
      bus.in_valid = 1'b1;
      bus.quot     = 8'd200;
      for (int i = 0; i < 5; i++) begin
         check("bp_bcd", 32'(bus.bcd), 32'h085);
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
      check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 50) begin
         tick();
         n++;
      end
      check("bp_held_latency", 32'(n), 32'd8);
      check("bp_held_bcd", 32'(bus.bcd), 32'h200);
      tick();
      // reset mid-conversion on the fourth shift of 255
      bus.in_valid = 1'b1;
      bus.quot     = 8'd255;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("mid_rst_bcd", 32'(bus.bcd), 32'd0);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.out_valid) n++;
         tick();
      end
      check("mid_rst_no_output", 32'(n), 32'd0);
      convert(8'd20, 1'b0, 12'h020, 1'b0, 8);
      // exhaustive sweep against the decimal model, digits must stay within 0..9
      for (int q = 0; q < 256; q++) begin
         convert(8'(q), 1'b0, bcd_ref(q), 1'b0, 8);
         check("digit_range", 32'((bus.bcd[11:8] > 9) || (bus.bcd[7:4] > 9) || (bus.bcd[3:0] > 9)), 32'd0);
      end
      for (int i = 0; i < 60; i++) begin
         rq  = 8'($urandom_range(0, 255));
         rdz = ($urandom_range(0, 7) == 0);
         convert(rq, rdz, rdz ? 12'hFFF : bcd_ref(int'(rq)), rdz, rdz ? 1 : 8);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
